reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the pipeline's 2-read/1-write register file.
- Provides two asynchronous read ports and two synchronous write ports, with a priority rule for writes to the same address.
- Optional same-cycle write-to-read bypass and an optional hardwired zero register.
- Carries a per-register pending (scoreboard) bit so hazard logic in decode can stall on an outstanding producer.

Parameters:
- WIDTH, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and never goes pending.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data; 0 = returns the stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- pr1  in  ADDR_W  read address, port 1.
- pr2  in  ADDR_W  read address, port 2.
- rd1  out  WIDTH  read data, port 1.
- rd2  out  WIDTH  read data, port 2.
- rd1_pend  out  1  pending bit of pr1.
- rd2_pend  out  1  pending bit of pr2.
- write1  in  1  write enable, port 1 (low priority).
- wr1  in  ADDR_W  write address, port 1.
- wd1  in  WIDTH  write data, port 1.
- write2  in  1  write enable, port 2 (high priority).
- wr2  in  ADDR_W  write address, port 2.
- wd2  in  WIDTH  write data, port 2.
- mark  in  1  set the pending bit of mark_addr.
- mark_addr  in  ADDR_W  register to mark pending.

Behaviour:
- Storage: DEPTH x WIDTH registers plus DEPTH pending bits.
- Reset (reset==0 at a clk edge):
  - All registers cleared to 0; all pending bits cleared.
  - Writes and marks in that cycle are ignored.
  - Reset mid-operation discards any in-flight write.
- Reads are combinational from pr1/pr2:
  - rd and rd_pend follow the address within the same cycle; 0 latency.
  - After reset, every read returns 0 and pend returns 0.
- Writes commit at the rising edge when reset==1:
  - write1 stores wd1 at wr1; write2 stores wd2 at wr2.
  - If both ports are enabled with wr1==wr2, wd2 is stored and wd1 is dropped.
- Bypass, BYPASS=1: priority order for a read at address A is
  - write2 active with wr2==A: return wd2;
  - else write1 active with wr1==A: return wd1;
  - else the stored value.
  - Pend for a bypassed read reports the post-edge value defined below.
- BYPASS=0: reads always return the stored value and the stored pending bit. The new value is visible from the cycle after the edge.
- ZERO_REG=1:
  - Reads of address 0 return 0 and pend 0 regardless of bypass.
  - Writes and marks to address 0 are discarded.
- Pending bits, per address A at each edge:
  - mark with mark_addr==A sets the bit.
  - Else a write (either port) to A clears the bit.
  - Else the bit holds.
  - Simultaneous mark and write to the same A: the value is written and the bit is set (the new producer wins).
  - A write to a non-pending register is legal and leaves the bit 0.
- Address wrap: addresses span exactly 0..DEPTH-1; there is no out-of-range case.
- Both read ports may use the same address; both return identical data.

Test Plan:
- Reset/clear: fill regs 1..31 with 32'hA5A5_0000+i, hold reset=0 for one edge, read all 32 addresses → all rd=0, all pend=0.
- Single write and zero register (ZERO_REG=1): write1=1, wr1=5, wd1=32'h10101010 → from the next cycle rd1(pr1=5)=32'h10101010. wr1=0, wd1=32'hFFFFFFFF → rd(pr=0)=0.
- Dual-write collision: same cycle, write1 (wr1=7, wd1=32'h1111_1111) and write2 (wr2=7, wd2=32'h2222_2222) → reg7=32'h2222_2222. Repeat with wr1=7, wr2=8 → reg7=32'h1111_1111, reg8=32'h2222_2222.
- Bypass: reg9=32'h0, pr2=9, write2 wr2=9 wd2=32'hCAFE_F00D in the same cycle.
  - BYPASS=1 → rd2=32'hCAFE_F00D before the edge.
  - BYPASS=0 → rd2=0 before the edge, 32'hCAFE_F00D after.
- Scoreboard: mark reg 12 → rd1_pend(pr1=12)=1 next cycle. Then write1 wr1=12 → pend=0 next cycle. Then mark and write2 to reg 12 in the same cycle → reg12=wd2, pend=1.
- Reset mid-operation: pend set on regs 3 and 4 and write1 to reg 3 active with reset=0 at the same edge → reg3=0, pend3=pend4=0. Then sweep pr2 31→24, one per cycle → all rd2=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-ported register file: two combinational read ports and two write ports
// (port 2 wins on collision), optional bypass and zero register, with per-register pending bits.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pr1,
  input  logic [ADDR_W-1:0] pr2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              rd1_pend,
  output logic              rd2_pend,
  input  logic              write1,
  input  logic [ADDR_W-1:0] wr1,
  input  logic [WIDTH-1:0]  wd1,
  input  logic              write2,
  input  logic [ADDR_W-1:0] wr2,
  input  logic [WIDTH-1:0]  wd2,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_we1;
  logic              w_we2;
  logic              w_mark;
  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_hit2;
  logic [DEPTH-1:0]  w_hitm;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [ADDR_W-1:0] w_ra [2];
  logic [WIDTH-1:0]  w_rd [2];
  logic              w_rp [2];

  // Register 0 is filtered out here so it can never be written or marked.
  assign w_we1  = write1 && !((ZERO_REG != 0) && (wr1 == '0));
  assign w_we2  = write2 && !((ZERO_REG != 0) && (wr2 == '0));
  assign w_mark = mark && !((ZERO_REG != 0) && (mark_addr == '0));

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    w_hitm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = w_we1 && (wr1 == ADDR_W'(i));
      w_hit2[i] = w_we2 && (wr2 == ADDR_W'(i));
      w_hitm[i] = w_mark && (mark_addr == ADDR_W'(i));
    end
  end

  // A mark in the same cycle as a write belongs to the new producer, so it wins.
  assign w_pend_nxt = (r_pend & ~(w_hit1 | w_hit2)) | w_hitm;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit2[i]) begin
          r_mem[i] <= wd2;
        end else if (w_hit1[i]) begin
          r_mem[i] <= wd1;
        end
      end
      r_pend <= w_pend_nxt;
    end
  end

  assign w_ra[0] = pr1;
  assign w_ra[1] = pr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_mem[w_ra[p]];
      w_rp[p] = r_pend[w_ra[p]];
      if (BYPASS != 0) begin
        if (w_we2 && (wr2 == w_ra[p])) begin
          w_rd[p] = wd2;
          w_rp[p] = w_pend_nxt[w_ra[p]];
        end else if (w_we1 && (wr1 == w_ra[p])) begin
          w_rd[p] = wd1;
          w_rp[p] = w_pend_nxt[w_ra[p]];
        end
      end
      if ((ZERO_REG != 0) && (w_ra[p] == '0)) begin
        w_rd[p] = '0;
        w_rp[p] = 1'b0;
      end
    end
  end

  assign rd1      = w_rd[0];
  assign rd2      = w_rd[1];
  assign rd1_pend = w_rp[0];
  assign rd2_pend = w_rp[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus
// and are checked against an array model of the register file.
module tb_reg_file_mp;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          reset, write1, write2, mark;
  logic [AW-1:0] pr1, pr2, wr1, wr2, mark_addr;
  logic [W-1:0]  wd1, wd2;
  logic [W-1:0]  rd1_b, rd2_b, rd1_n, rd2_n;
  logic          rp1_b, rp2_b, rp1_n, rp2_n;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .pr1(pr1), .pr2(pr2),
    .rd1(rd1_b), .rd2(rd2_b), .rd1_pend(rp1_b), .rd2_pend(rp2_b),
    .write1(write1), .wr1(wr1), .wd1(wd1),
    .write2(write2), .wr2(wr2), .wd2(wd2),
    .mark(mark), .mark_addr(mark_addr));

  reg_file_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_dut_nob (
    .clk(clk), .reset(reset), .pr1(pr1), .pr2(pr2),
    .rd1(rd1_n), .rd2(rd2_n), .rd1_pend(rp1_n), .rd2_pend(rp2_n),
    .write1(write1), .wr1(wr1), .wd1(wd1),
    .write2(write2), .wr2(wr2), .wd2(wd2),
    .mark(mark), .mark_addr(mark_addr));

  typedef struct packed {
    logic [W-1:0] d1b, d2b, d1n, d2n;
    logic         p1b, p2b, p1n, p2n;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] m_mem  [D];
  logic         m_pend [D];
  logic [W-1:0] n_mem  [D];
  logic         n_pend [D];

  // Post-edge contents if this cycle's operations are applied in order; later ops override earlier ones.
  function automatic void plan();
    n_mem  = m_mem;
    n_pend = m_pend;
    if (write1 && wr1 != '0) begin n_mem[wr1] = wd1; n_pend[wr1] = 1'b0; end
    if (write2 && wr2 != '0) begin n_mem[wr2] = wd2; n_pend[wr2] = 1'b0; end
    if (mark && mark_addr != '0) n_pend[mark_addr] = 1'b1;
  endfunction

  function automatic void peek(input logic [AW-1:0] a, input bit byp,
                               output logic [W-1:0] d, output logic p);
    if (a == '0) begin
      d = '0; p = 1'b0;
    end else if (byp && ((write1 && wr1 == a) || (write2 && wr2 == a))) begin
      d = n_mem[a]; p = n_pend[a];
    end else begin
      d = m_mem[a]; p = m_pend[a];
    end
  endfunction

  task automatic step(input bit chk);
    exp_t e;
    plan();
    if (chk) begin
      peek(pr1, 1'b1, e.d1b, e.p1b);
      peek(pr2, 1'b1, e.d2b, e.p2b);
      peek(pr1, 1'b0, e.d1n, e.p1n);
      peek(pr2, 1'b0, e.d2n, e.p2n);
      q.push_back(e);
    end
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    end else begin
      m_mem  = n_mem;
      m_pend = n_pend;
    end
    #1;
  endtask

  task automatic drive(input bit rst, input bit w1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                       input bit w2, input logic [AW-1:0] a2, input logic [W-1:0] d2,
                       input bit mk, input logic [AW-1:0] ma,
                       input logic [AW-1:0] p1, input logic [AW-1:0] p2, input bit chk = 1'b1);
    reset = rst; write1 = w1; wr1 = a1; wd1 = d1;
    write2 = w2; wr2 = a2; wd2 = d2; mark = mk; mark_addr = ma;
    pr1 = p1; pr2 = p2;
    step(chk);
  endtask

  task automatic idle(input logic [AW-1:0] p1, input logic [AW-1:0] p2);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, p1, p2);
  endtask

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check_w("rd1_byp", rd1_b, e.d1b);
        check_w("rd2_byp", rd2_b, e.d2b);
        check_b("pend1_byp", rp1_b, e.p1b);
        check_b("pend2_byp", rp2_b, e.p2b);
        check_w("rd1_nob", rd1_n, e.d1n);
        check_w("rd2_nob", rd2_n, e.d2n);
        check_b("pend1_nob", rp1_n, e.p1n);
        check_b("pend2_nob", rp2_n, e.p2n);
      end
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, D - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin : stimulus
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);

    // Fill, reset, then sweep every address.
    for (int i = 1; i < D; i++)
      drive(1'b1, 1'b1, AW'(i), 32'hA5A5_0000 + W'(i), 1'b0, '0, '0,
            1'b1, AW'(i), AW'(i), AW'(i - 1));
    drive(1'b0, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd4, 32'h8765_4321, 1'b1, 5'd6, 5'd1, 5'd2);
    for (int k = 0; k < D / 2; k++) idle(AW'(2 * k), AW'(2 * k + 1));

    // Single write, then writes to the zero register.
    drive(1'b1, 1'b1, 5'd5, 32'h1010_1010, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd5);

    // Dual-write collision, then distinct addresses.
    drive(1'b1, 1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, 1'b0, '0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    drive(1'b1, 1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd8, 32'h2222_2222, 1'b0, '0, 5'd7, 5'd8);
    idle(5'd7, 5'd8);

    // Bypass on read port 2.
    drive(1'b1, 1'b1, 5'd9, 32'h0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, '0, 5'd1, 5'd9);
    idle(5'd1, 5'd9);

    // Pending bit life cycle on register 12.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 5'd12, 5'd12);
    idle(5'd12, 5'd12);
    drive(1'b1, 1'b1, 5'd12, 32'h0000_0C0C, 1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd12);
    idle(5'd12, 5'd12);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd12, 32'h0C0C_0C0C, 1'b1, 5'd12, 5'd12, 5'd12);
    idle(5'd12, 5'd12);

    // Reset while a write and marks are in flight.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd4);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd3, 5'd4);
    drive(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b1, 5'd4, 5'd3, 5'd4);
    idle(5'd3, 5'd4);
    for (int a = 31; a >= 24; a--) idle(5'd3, AW'(a));

    // Randomized traffic concentrated on a few registers to force collisions.
    for (int n = 0; n < 600; n++)
      drive(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1, rnd_addr(), $urandom(),
            $urandom_range(0, 1) == 1, rnd_addr(), $urandom(),
            $urandom_range(0, 2) == 0, rnd_addr(), rnd_addr(), rnd_addr());

    idle('0, '0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
